// File: rtl/kernel_map_pkg.sv
// Shared opcodes and defaults for the generated map-node datapath.
package kernel_map_pkg;

    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_ADD = 3'd0;
    localparam logic [OPW-1:0] OP_SUB = 3'd1;
    localparam logic [OPW-1:0] OP_MUL = 3'd2;
    localparam logic [OPW-1:0] OP_MIN = 3'd3;
    localparam logic [OPW-1:0] OP_MAX = 3'd4;

    localparam int unsigned DEF_DATAW      = 32;
    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned DEF_PIPE_DEPTH = 2;
    localparam int unsigned DEF_CNTW       = 32;

endpackage

// File: rtl/kernel_map_lane_alu.sv
// One lane of the map node: signed binary op with overflow detection.
module kernel_map_lane_alu
    import kernel_map_pkg::*;
#(
    parameter int unsigned DATAW = DEF_DATAW
) (
    input  logic [DATAW-1:0] a,
    input  logic [DATAW-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [DATAW-1:0] res,
    output logic             ovf
);

    logic [DATAW:0]            sum;
    logic [DATAW:0]            dif;
    logic signed [2*DATAW-1:0] ax;
    logic signed [2*DATAW-1:0] bx;
    logic signed [2*DATAW-1:0] prod;
    logic                      a_lt_b;

    // One guard bit: overflow when the guard and sign bits disagree.
    assign sum    = {a[DATAW-1], a} + {b[DATAW-1], b};
    assign dif    = {a[DATAW-1], a} - {b[DATAW-1], b};
    assign ax     = {{DATAW{a[DATAW-1]}}, a};
    assign bx     = {{DATAW{b[DATAW-1]}}, b};
    assign prod   = ax * bx;
    assign a_lt_b = $signed(a) < $signed(b);

    always_comb begin
        res = a;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum[DATAW-1:0];
                ovf = sum[DATAW] ^ sum[DATAW-1];
            end
            OP_SUB: begin
                res = dif[DATAW-1:0];
                ovf = dif[DATAW] ^ dif[DATAW-1];
            end
            OP_MUL: begin
                res = prod[DATAW-1:0];
                ovf = prod[2*DATAW-1:DATAW] != {DATAW{prod[DATAW-1]}};
            end
            OP_MIN: res = a_lt_b ? a : b;
            OP_MAX: res = a_lt_b ? b : a;
            default: ;
        endcase
    end

endmodule

// File: rtl/kernel_map_node_pipe.sv
// Leaf map node: LANES parallel ALUs feeding a PIPE_DEPTH-stage stallable pipeline,
// with emitted-beat counter and sticky per-lane overflow.
module kernel_map_node_pipe
    import kernel_map_pkg::*;
#(
    parameter int unsigned DATAW      = DEF_DATAW,
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int unsigned CNTW       = DEF_CNTW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   in_valid,
    input  logic [OPW-1:0]         op,
    input  logic [LANES*DATAW-1:0] in1,
    input  logic [LANES*DATAW-1:0] in2,
    output logic [LANES*DATAW-1:0] out1,
    output logic                   out_valid,
    output logic [LANES-1:0]       ovf,
    output logic [LANES-1:0]       ovf_sticky,
    input  logic                   ovf_clr,
    output logic                   busy,
    output logic [CNTW-1:0]        res_count
);

    localparam int unsigned BUSW = LANES * DATAW;

    logic [BUSW-1:0]       alu_res;
    logic [LANES-1:0]      alu_ovf;

    logic [BUSW-1:0]       data_q [PIPE_DEPTH];
    logic [LANES-1:0]      ovf_q  [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] valid_q;

    logic                  last_valid_d;
    logic [LANES-1:0]      last_ovf_d;
    logic                  emit;
    logic [CNTW-1:0]       res_count_d, res_count_q;
    logic [LANES-1:0]      sticky_d, sticky_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        kernel_map_lane_alu #(
            .DATAW (DATAW)
        ) u_alu (
            .a   (in1[l*DATAW +: DATAW]),
            .b   (in2[l*DATAW +: DATAW]),
            .op  (op),
            .res (alu_res[l*DATAW +: DATAW]),
            .ovf (alu_ovf[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
                data_q[i] <= '0;
                ovf_q[i]  <= '0;
            end
        end else if (!stall) begin
            data_q[0]  <= alu_res;
            ovf_q[0]   <= alu_ovf;
            valid_q[0] <= in_valid;
            for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
                data_q[i]  <= data_q[i-1];
                ovf_q[i]   <= ovf_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // What the last stage is about to load; with one stage that is the ALU itself.
    if (PIPE_DEPTH == 1) begin : g_single
        assign last_valid_d = in_valid;
        assign last_ovf_d   = alu_ovf;
    end else begin : g_multi
        assign last_valid_d = valid_q[PIPE_DEPTH-2];
        assign last_ovf_d   = ovf_q[PIPE_DEPTH-2];
    end

    always_comb begin
        emit        = !stall && last_valid_d;
        res_count_d = res_count_q + CNTW'(emit);
        // Clear first, then OR in new overflows so a coincident set wins.
        sticky_d    = (ovf_clr ? '0 : sticky_q) | (emit ? last_ovf_d : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            res_count_q <= '0;
            sticky_q    <= '0;
        end else begin
            res_count_q <= res_count_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out1       = data_q[PIPE_DEPTH-1];
    assign ovf        = ovf_q[PIPE_DEPTH-1];
    assign out_valid  = valid_q[PIPE_DEPTH-1];
    assign busy       = |valid_q;
    assign res_count  = res_count_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: doc/kernel_map_node_pipe.md
Name: kernel_map_node_pipe

Overview:
- Parametrised leaf map node for TyBEC-generated kernels. Applies one runtime-selected binary op across LANES parallel lanes, then passes the results through a PIPE_DEPTH-stage registered pipeline.
- Carries valid, stall and per-lane overflow information alongside the data.
- Sits between kernel stream ports, or between chained map nodes, in the generated datapath.

Parameters:
- DATAW, 32, lane operand/result width in bits (2..64).
- LANES, 4, number of parallel lanes (1..16).
- PIPE_DEPTH, 2, register stages from input to output (1..8).
- CNTW, 32, width of the emitted-result counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset: rst==0 at a clk rising edge resets the block.
- stall  in  1  freezes the whole pipeline while high.
- in_valid  in  1  input beat valid.
- op  in  3  operation select, sampled with each accepted beat.
- in1  in  LANES*DATAW  lane operands A; lane l occupies bits [l*DATAW +: DATAW].
- in2  in  LANES*DATAW  lane operands B.
- out1  out  LANES*DATAW  lane results, registered.
- out_valid  out  1  out1 holds a valid result.
- ovf  out  LANES  per-lane overflow flag of the current out1 beat.
- ovf_sticky  out  LANES  per-lane sticky overflow.
- ovf_clr  in  1  clears ovf_sticky.
- busy  out  1  at least one valid beat is in flight in any stage.
- res_count  out  CNTW  number of valid beats emitted.

Behaviour:
- Reset (rst==0 at posedge): every stage's data, valid and ovf registers cleared. out1=0, out_valid=0, ovf=0, ovf_sticky=0, busy=0, res_count=0. Reset overrides stall and takes effect mid-operation; in-flight beats are discarded.
- Ops (signed two's complement, results truncated to DATAW):
  - 0 ADD: in1+in2; ovf on signed overflow.
  - 1 SUB: in1-in2; ovf on signed overflow.
  - 2 MUL: low DATAW bits of the 2*DATAW signed product; ovf when the full product is not representable in DATAW.
  - 3 MIN: signed minimum; ovf=0.
  - 4 MAX: signed maximum; ovf=0.
  - 5..7: pass in1; ovf=0.
- Stage 0 registers the combinational lane results, the ovf bits and in_valid. Stages 1..PIPE_DEPTH-1 shift data, valid and ovf forward unchanged. out1, out_valid and ovf are the last stage.
- Latency: a beat accepted at edge N appears on out1 with out_valid=1 after edge N+PIPE_DEPTH-1, plus one cycle per stall cycle in between. Throughput is one beat per non-stall cycle.
- Accept: a beat is accepted when in_valid=1 and stall=0. Invalid beats propagate as bubbles. Data registers load on every non-stall cycle regardless of valid; the contents of bubble stages are don't-care but deterministic.
- Stall=1: every pipeline register holds its value. in_valid is ignored, and upstream must hold its data. out1, out_valid and ovf are held; res_count and ovf_sticky do not update.
- op is carried implicitly: the result is computed at stage-0 capture, so changing op affects only later beats.
- res_count increments by 1 on each non-stall edge at which the last stage is updated with a valid beat, i.e. when that beat becomes visible on out_valid. It wraps from 2^CNTW-1 to 0.
- ovf_sticky[l] is set on the same condition as the res_count increment when that beat's ovf[l]=1. ovf_clr=1 clears all bits. If set and clear occur in the same cycle, set wins. ovf_clr is honoured during stall.
- busy is the combinational OR of all stage valid bits.
- PIPE_DEPTH=1: a single register stage and no shift stages.

Decomposition:
- Shared package kernel_map_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_MIN=3, OP_MAX=4;
  - OPW=3;
  - default parameter values.
- One sub-module, kernel_map_lane_alu: combinational, parametrised on DATAW, inputs a, b, op, outputs res and ovf. Instantiated LANES times in a generate loop.
- The pipeline and counters live in the top module.

Test Plan:
- Reset/basic (LANES=4, DATAW=32, PIPE_DEPTH=2): hold rst=0 for 3 cycles; all outputs read 0. Release, then send ADD with in1 lanes {1,2,3,4}, in2 {10,20,30,40}. Expect out1 {11,22,33,44} with out_valid=1 exactly 2 cycles after acceptance, and res_count=1.
- Overflow: ADD 0x7FFFFFFF+1 on lane 0 gives 0x80000000 with ovf[0]=1 and ovf_sticky[0]=1. Other lanes 0+0 give ovf=0. ovf_clr for 1 cycle clears the sticky bit. Repeat with the overflowing beat emitted in the same cycle as ovf_clr; sticky stays 1.
- MUL/MIN/MAX: MUL -3*5 gives -15 with ovf=0. MUL 0x10000*0x10000 gives 0 with ovf=1. MIN(-1,2)=-1; MAX(-1,2)=2.
- Stall mid-flight: stream 4 back-to-back beats; assert stall for 3 cycles after the 2nd acceptance. Outputs and busy are frozen during the stall; all 4 results emerge in order, last one PIPE_DEPTH+3 cycles after the 4th beat's first presentation; res_count=4.
- Bubbles/reset: pattern valid,invalid,valid gives out_valid 1,0,1 in sequence. Apply rst=0 with 2 beats in flight; both are discarded, busy=0 and res_count=0 the next cycle.
- Wrap and corner params (CNTW=4, LANES=1, PIPE_DEPTH=1): 17 valid beats leave res_count=1, and each result appears 1 cycle after acceptance.
